// File: rtl/ws2812_in.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_in
//  Description : WS2812 one-wire line receiver. Synchronises the serial line,
//                measures each high pulse, decodes bits MSB-first into bytes
//                and detects the low reset gap that terminates a frame.
//  Ports       : clk_in          system clock
//                rst_n_in        asynchronous reset, active low
//                ws2812_data_in  serial line (asynchronous to clk_in)
//                bit_thr_cnt_in  high time above this count decodes '1'
//                rst_cnt_in      low time that ends a frame (0 = never)
//                byte_vld_out    1-cycle strobe for byte_data_out/byte_idx_out
//                byte_data_out   decoded byte, first received bit in bit 7
//                byte_idx_out    byte position within the frame
//                frame_done_out  1-cycle strobe at frame end
//                byte_cnt_out    whole bytes in the last frame (held)
//                err_out         [0] stuck-high pulse, [1] partial byte
//  Options     : WS2812_IN_ERR_EN  enables the sticky error flags; when
//                undefined err_out is tied to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module ws2812_in #(
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             ws2812_data_in,
    input  logic [7:0]       bit_thr_cnt_in,
    input  logic [15:0]      rst_cnt_in,
    output logic             byte_vld_out,
    output logic [7:0]       byte_data_out,
    output logic [IDX_W-1:0] byte_idx_out,
    output logic             frame_done_out,
    output logic [IDX_W-1:0] byte_cnt_out,
    output logic [1:0]       err_out
);

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        IDLE     = 2'd1,
        HIGH     = 2'd2,
        LOW      = 2'd3
    } state_t;

    state_t r_state, w_state_next;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_line_q;
    logic [7:0]             r_hi_cnt;
    logic [15:0]            r_lo_cnt;
    logic [6:0]             r_shift;     // seven most recent bits of the byte in progress
    logic [2:0]             r_bit_cnt;
    logic [IDX_W-1:0]       r_byte_idx;

    // Event strobes are staged one cycle before reaching the outputs, so a
    // byte completion always surfaces before a frame end that follows it.
    logic                   r_vld_pend;
    logic [7:0]             r_data_pend;
    logic [IDX_W-1:0]       r_idx_pend;
    logic                   r_done_pend;
    logic [IDX_W-1:0]       r_cnt_pend;

    logic w_line, w_rise, w_fall, w_gap, w_bit;
    logic w_start_hi, w_decode, w_frame_end;

    assign w_line = r_sync[SYNC_STAGES-1];
    assign w_rise = w_line & ~r_line_q;
    assign w_fall = ~w_line & r_line_q;
    assign w_gap  = (rst_cnt_in != 16'd0) && (r_lo_cnt >= rst_cnt_in);
    assign w_bit  = (r_hi_cnt > bit_thr_cnt_in);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_sync   <= '0;
            r_line_q <= 1'b0;
            r_state  <= WAIT_GAP;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], ws2812_data_in};
            r_line_q <= w_line;
            r_state  <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_hi   = 1'b0;
        w_decode     = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            WAIT_GAP: begin
                if (w_gap) w_state_next = IDLE;
            end
            IDLE: begin
                if (w_rise) begin
                    w_state_next = HIGH;
                    w_start_hi   = 1'b1;
                end
            end
            HIGH: begin
                if (w_fall) begin
                    w_state_next = LOW;
                    w_decode     = 1'b1;
                end
            end
            LOW: begin
                if (w_rise) begin
                    w_state_next = HIGH;
                    w_start_hi   = 1'b1;
                end else if (w_gap) begin
                    w_state_next = IDLE;
                    w_frame_end  = 1'b1;
                end
            end
            default: w_state_next = WAIT_GAP;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_hi_cnt       <= 8'd0;
            r_lo_cnt       <= 16'd0;
            r_shift        <= 7'd0;
            r_bit_cnt      <= 3'd0;
            r_byte_idx     <= '0;
            r_vld_pend     <= 1'b0;
            r_data_pend    <= 8'd0;
            r_idx_pend     <= '0;
            r_done_pend    <= 1'b0;
            r_cnt_pend     <= '0;
            byte_vld_out   <= 1'b0;
            byte_data_out  <= 8'd0;
            byte_idx_out   <= '0;
            frame_done_out <= 1'b0;
            byte_cnt_out   <= '0;
        end else begin
            if (w_start_hi)
                r_hi_cnt <= 8'd1;
            else if (r_state == HIGH && r_hi_cnt != 8'hFF)
                r_hi_cnt <= r_hi_cnt + 8'd1;

            // Low time is measured both while hunting for the first gap and
            // between bits; any high level restarts the WAIT_GAP measurement.
            if (w_decode)
                r_lo_cnt <= 16'd1;
            else if (r_state == WAIT_GAP && w_line)
                r_lo_cnt <= 16'd0;
            else if ((r_state == WAIT_GAP || r_state == LOW) && r_lo_cnt != 16'hFFFF)
                r_lo_cnt <= r_lo_cnt + 16'd1;

            r_vld_pend  <= w_decode && (r_bit_cnt == 3'd7);
            r_done_pend <= w_frame_end;

            if (w_decode) begin
                r_shift <= {r_shift[5:0], w_bit};
                if (r_bit_cnt == 3'd7) begin
                    r_data_pend <= {r_shift, w_bit};
                    r_idx_pend  <= r_byte_idx;
                    r_byte_idx  <= r_byte_idx + 1'b1;
                    r_bit_cnt   <= 3'd0;
                end else begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
            end else if (w_frame_end) begin
                r_cnt_pend <= r_byte_idx;
                r_byte_idx <= '0;
                r_bit_cnt  <= 3'd0;
                r_shift    <= 7'd0;
            end

            byte_vld_out   <= r_vld_pend;
            frame_done_out <= r_done_pend;
            if (r_vld_pend) begin
                byte_data_out <= r_data_pend;
                byte_idx_out  <= r_idx_pend;
            end
            if (r_done_pend)
                byte_cnt_out <= r_cnt_pend;
        end
    end

`ifdef WS2812_IN_ERR_EN
    logic [1:0] r_err;
    logic       r_perr_pend;

    // Flags are sticky for a whole frame and are reported alongside
    // frame_done_out; they drop on the cycle after it.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_err       <= 2'b00;
            r_perr_pend <= 1'b0;
        end else begin
            if (w_frame_end)
                r_perr_pend <= (r_bit_cnt != 3'd0);
            if (frame_done_out) begin
                r_err <= 2'b00;
            end else begin
                if (r_done_pend && r_perr_pend)
                    r_err[1] <= 1'b1;
                if (r_state == HIGH && r_hi_cnt == 8'hFF)
                    r_err[0] <= 1'b1;
            end
        end
    end

    assign err_out = r_err;
`else
    assign err_out = 2'b00;
`endif

endmodule
`default_nettype wire
